uart_tx_serializer: RTL

// - Transmit half of the board's 8N1 UART link: serializes one byte per request onto a TX line.
// - Pairs with the existing UART_RX receiver at the same bit timing.
// - Default timing is 25 MHz / 115200 baud, CLKS_PER_BIT = 217.
// - Sits between user logic (byte source with valid/ready handshake) and the FPGA TX pin to the USB-serial bridge.

---
 rtl/uart_tx_serializer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 UART transmit serializer with a valid/ready byte input
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 217,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Serial,
  output logic       o_TX_Ready,
  output logic       o_TX_Active,
  output logic       o_TX_Done
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift_reg, shift_n;
  logic             serial_n, ready_n, active_n, done_n;
  logic             accept, bit_end;

  assign accept  = i_TX_DV && o_TX_Ready;
  assign bit_end = (clk_cnt == CNT_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Ready  <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      bit_idx     <= bit_idx_n;
      shift_reg   <= shift_n;
      o_TX_Serial <= serial_n;
      o_TX_Ready  <= ready_n;
      o_TX_Active <= active_n;
      o_TX_Done   <= done_n;
    end
  end

  // Outputs are computed one cycle ahead so they leave the block registered.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    serial_n  = o_TX_Serial;
    ready_n   = o_TX_Ready;
    active_n  = o_TX_Active;
    done_n    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_n  = IDLE;
        serial_n = 1'b1;
        ready_n  = 1'b1;
        active_n = 1'b0;
        if (accept) begin
          state_n   = START;
          shift_n   = i_TX_Byte;
          clk_cnt_n = '0;
          bit_idx_n = '0;
          serial_n  = 1'b0;
          ready_n   = 1'b0;
          active_n  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          clk_cnt_n = '0;
          serial_n  = shift_reg[0];
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n   = STOP;
            bit_idx_n = '0;
            serial_n  = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift_reg[7:1]};
            serial_n  = shift_reg[1];
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        // bit_idx is reused to count stop bits.
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            state_n   = DONE;
            bit_idx_n = '0;
            serial_n  = 1'b1;
            ready_n   = 1'b1;
            active_n  = 1'b0;
            done_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
